beat_timer: RTL and testbench
=============================

# beat_timer

Beat and phase generator for the hard-wired CPU. It sits directly upstream of the instruction controller and supplies the beat levels W1/W2/W3 and the phase pulses T1/T2/T3 that the controller consumes. It lengthens or shortens each machine cycle from the controller's SHORT/LONG requests and halts on STOP. It starts when the operator presses QD.

## Interface
- CYCW, 16: width of the machine-cycle counter CYC.

- CLK, in, 1: master clock; all state changes on the rising edge.
- clr, in, 1: reset, asynchronous, active-low.
- QD, in, 1: start button, asynchronous level; its rising edge starts the machine.
- SHORT, in, 1: controller request to end the machine cycle after W1.
- LONG, in, 1: controller request to add W3 after W2.
- STOP, in, 1: controller request to halt at the end of the current machine cycle.
- T1, T2, T3, out, 1 each: phase pulses; one-hot while running, each high for one CLK.
- W1, W2, W3, out, 1 each: beat levels; one-hot while running, each held for one full T1–T3 sequence.
- RUN, out, 1: high while beats are being generated.
- CYC, out, CYCW: count of completed machine cycles.

## Operation
- States: IDLE, W1, W2, W3. Phase counter PH cycles through T1→T2→T3→T1 while not IDLE.
- Reset (clr=0), effective immediately:
  - T1–T3, W1–W3 and RUN = 0; CYC = 0; state = IDLE.
  - Both QD synchroniser flops are set to 1, so a QD held high through reset does not start the machine.
- QD handling: two-flop synchroniser, then rising-edge detect (sync2 & ~sync3).
  - In IDLE, a detected edge → state W1, PH=T1, RUN=1.
  - Outside IDLE, QD edges are ignored.
- Beat transitions happen only on the CLK edge that ends T3. SHORT, LONG and STOP are sampled during the T3 cycle of the current beat.
  - From W1: SHORT=1 → end of machine cycle; otherwise go to W2.
  - From W2: LONG=1 → go to W3; otherwise end of machine cycle. SHORT is ignored in W2.
  - From W3: end of machine cycle unconditionally.
- End of machine cycle:
  - CYC += 1, modulo 2^CYCW (0xFFFF wraps to 0x0000).
  - If STOP=1, go to IDLE: all T/W outputs = 0 and RUN = 0 on the following cycle.
  - Otherwise go to W1 with PH=T1.
- STOP sampled on any beat that does not end the machine cycle has no effect.
- SHORT and LONG both high in W1: SHORT wins, and the cycle ends after W1.
- SHORT, LONG and STOP are sampled only in T3, so glitches during T1/T2 are harmless.

## Timing
- All outputs are registered, with no combinational paths from input to output.
- Start latency: let edge 0 be the first rising CLK edge that samples QD=1. T1, W1 and RUN go high after edge 3.
- Each beat lasts exactly 3 CLK cycles, in the order T1, T2, T3.
- Machine-cycle length: 3 CLK when SHORT, 6 CLK normally, 9 CLK when LONG.
- W changes on the same edge that takes PH from T3 to T1, so the falling edge of T3 coincides with the beat change. The controller's negedge-T3 registers therefore see stable W levels.
- STOP halt: the edge that ends the final T3 drops every output to 0. The next T1 appears 3 edges after a new QD edge is sampled.
- Reset mid-beat: outputs clear asynchronously. CYC is not incremented for the partial cycle.

## Test plan
- Reset, then release clr with QD held high → RUN stays 0 for 20 CLK. Drop QD and raise it again → T1 and W1 high after edge 3, then T2, then T3.
- SHORT=1, LONG=0, STOP=0 → the pattern W1,W1,W1 repeats; T1/T2/T3 one-hot every cycle; CYC increments every 3 CLK.
- SHORT=0, LONG=1 → W1×3, W2×3, W3×3 per machine cycle; CYC increments every 9 CLK. LONG=0 → W1×3, W2×3 only.
- SHORT=1 and LONG=1 together in W1 → no W2 appears. SHORT=1 asserted only in W2 with LONG=1 → W3 still follows.
- STOP pulsed high in W1 T3 of a 2-beat cycle → no halt. STOP high in W2 T3 → all outputs 0 and RUN=0 on the next cycle; CYC incremented once. QD edges while running do not disturb the beat sequence.
- Preload CYC to 0xFFFE by running cycles, complete two more machine cycles → CYC reads 0xFFFF, then 0x0000. Assert clr in the middle of W2 T2 → all outputs 0 immediately, CYC=0.

Source files
------------

// File: rtl/beat_timer.sv
// beat_timer: beat (W1-W3) and phase (T1-T3) generator for the hard-wired CPU.
// Machine cycles are stretched or shortened by SHORT/LONG and halted by STOP.
module beat_timer #(
  parameter int CYCW = 16
) (
  input  logic            CLK,
  input  logic            clr,
  input  logic            QD,
  input  logic            SHORT,
  input  logic            LONG,
  input  logic            STOP,
  output logic            T1,
  output logic            T2,
  output logic            T3,
  output logic            W1,
  output logic            W2,
  output logic            W3,
  output logic            RUN,
  output logic [CYCW-1:0] CYC
);

  typedef enum logic [1:0] {
    IDLE,
    S_W1,
    S_W2,
    S_W3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [1:0]      ph;
  logic [1:0]      ph_n;
  logic [CYCW-1:0] cyc_n;
  logic [2:0]      t_q;
  logic [2:0]      t_n;
  logic [2:0]      w_q;
  logic [2:0]      w_n;
  logic            run_n;
  logic            sync1;
  logic            sync2;
  logic            sync3;
  logic            go;
  logic            end_cyc;

  // Sync flops reset high so a QD held through reset is not an edge;
  // go adds one stage so T1 lands three edges after QD is first seen.
  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
      go    <= 1'b0;
      state <= IDLE;
      ph    <= 2'd0;
      CYC   <= '0;
      t_q   <= 3'b000;
      w_q   <= 3'b000;
      RUN   <= 1'b0;
    end else begin
      sync1 <= QD;
      sync2 <= sync1;
      sync3 <= sync2;
      go    <= sync2 & ~sync3;
      state <= state_n;
      ph    <= ph_n;
      CYC   <= cyc_n;
      t_q   <= t_n;
      w_q   <= w_n;
      RUN   <= run_n;
    end
  end

  always_comb begin
    state_n = state;
    ph_n    = ph;
    cyc_n   = CYC;
    end_cyc = 1'b0;
    unique case (state)
      IDLE: begin
        ph_n = 2'd0;
        if (go) state_n = S_W1;
      end
      S_W1: begin
        if (ph == 2'd2) begin
          if (SHORT) end_cyc = 1'b1;
          else       state_n = S_W2;
        end
      end
      S_W2: begin
        if (ph == 2'd2) begin
          if (LONG) state_n = S_W3;
          else      end_cyc = 1'b1;
        end
      end
      S_W3: begin
        if (ph == 2'd2) end_cyc = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE) begin
      if (ph == 2'd2) ph_n = 2'd0;
      else            ph_n = 2'(ph + 2'd1);
    end
    if (end_cyc) begin
      cyc_n   = CYC + CYCW'(1);
      state_n = STOP ? IDLE : S_W1;
    end
  end

  // Outputs are decoded from next state and then registered.
  always_comb begin
    t_n   = 3'b000;
    w_n   = 3'b000;
    run_n = (state_n != IDLE);
    unique case (state_n)
      S_W1:    w_n = 3'b001;
      S_W2:    w_n = 3'b010;
      S_W3:    w_n = 3'b100;
      default: w_n = 3'b000;
    endcase
    if (run_n) begin
      unique case (ph_n)
        2'd0:    t_n = 3'b001;
        2'd1:    t_n = 3'b010;
        default: t_n = 3'b100;
      endcase
    end
  end

  assign T1 = t_q[0];
  assign T2 = t_q[1];
  assign T3 = t_q[2];
  assign W1 = w_q[0];
  assign W2 = w_q[1];
  assign W3 = w_q[2];

endmodule

// File: tb/tb_beat_timer.sv
// tb_beat_timer: table-driven, directed and random checks of beat_timer
// against a clock-count model of the beat schedule.
module tb_beat_timer;

  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          clr = 1'b0;
  logic          QD = 1'b1;
  logic          SHORT = 1'b0;
  logic          LONG = 1'b0;
  logic          STOP = 1'b0;
  logic          T1, T2, T3, W1, W2, W3, RUN;
  logic [CW-1:0] CYC;

  int errs = 0;
  int checks = 0;

  bit m_run;
  int m_cnt;
  int m_cyc;
  bit qh[$];

  typedef struct {
    bit sh;
    bit lg;
    bit st;
    int nclk;
    int dcyc;
    int nw2;
    int nw3;
  } vec_t;

  vec_t tbl[5];

  always #5 CLK = ~CLK;

  beat_timer #(.CYCW(CW)) dut (
    .CLK  (CLK),
    .clr  (clr),
    .QD   (QD),
    .SHORT(SHORT),
    .LONG (LONG),
    .STOP (STOP),
    .T1   (T1),
    .T2   (T2),
    .T3   (T3),
    .W1   (W1),
    .W2   (W2),
    .W3   (W3),
    .RUN  (RUN),
    .CYC  (CYC)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_cnt = 0;
    m_cyc = 0;
    qh.delete();
    repeat (5) qh.push_back(1'b1);
  endtask

  // One rising edge: start needs QD seen 1 three edges ago after a 0.
  task automatic model_step();
    bit start;
    bit endc;
    int beat;
    qh.push_back(QD);
    while (qh.size() > 6) void'(qh.pop_front());
    start = qh[qh.size()-4] && !qh[qh.size()-5];
    if (!m_run) begin
      if (start) begin
        m_run = 1'b1;
        m_cnt = 0;
      end
    end else if (m_cnt % 3 != 2) begin
      m_cnt++;
    end else begin
      beat = m_cnt / 3 + 1;
      endc = (beat == 1 && SHORT) || (beat == 2 && !LONG) || beat == 3;
      if (endc) begin
        m_cyc = (m_cyc + 1) % (1 << CW);
        m_cnt = 0;
        if (STOP) m_run = 1'b0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_all(input string nm);
    logic [2:0] et;
    logic [2:0] ew;
    et = m_run ? 3'(1 << (m_cnt % 3)) : 3'b000;
    ew = m_run ? 3'(1 << (m_cnt / 3)) : 3'b000;
    chk(nm, 32'({T3, T2, T1, W3, W2, W1, RUN, CYC}),
        32'({et, ew, m_run, CW'(m_cyc)}));
  endtask

  task automatic step(input bit q, input bit s, input bit l, input bit p);
    QD = q;
    SHORT = s;
    LONG = l;
    STOP = p;
    @(posedge CLK);
    if (clr) model_step();
    else     model_reset();
    @(negedge CLK);
    check_all("step");
  endtask

  task automatic align();
    int n;
    n = 0;
    while (!(m_run && m_cnt == 0) && n < 20) begin
      step(0, 0, 0, 0);
      n++;
    end
    chk("align", 32'(m_run && m_cnt == 0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] c0;
    int n2;
    int n3;
    int guard;

    tbl[0] = '{1, 0, 0, 9, 3, 0, 0};
    tbl[1] = '{0, 1, 0, 18, 2, 6, 6};
    tbl[2] = '{0, 0, 0, 12, 2, 6, 0};
    tbl[3] = '{1, 1, 0, 6, 2, 0, 0};
    tbl[4] = '{0, 0, 0, 6, 1, 3, 0};

    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_all("reset");
    clr = 1'b1;

    repeat (20) step(1, 0, 0, 0);
    chk("qd_held_run", 32'(RUN), 32'd0);

    repeat (3) step(0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    chk("pre_start", 32'(RUN), 32'd0);
    step(1, 0, 0, 0);
    chk("start_t1", 32'({T1, W1, RUN}), 32'b111);
    step(1, 0, 0, 0);
    chk("start_t2", 32'({T2, W1}), 32'b11);
    step(1, 0, 0, 0);
    chk("start_t3", 32'({T3, W1}), 32'b11);
    align();

    foreach (tbl[k]) begin
      c0 = CYC;
      n2 = 0;
      n3 = 0;
      for (int i = 0; i < tbl[k].nclk; i++) begin
        step(0, tbl[k].sh, tbl[k].lg, tbl[k].st);
        n2 += int'(W2);
        n3 += int'(W3);
      end
      chk($sformatf("tbl%0d_dcyc", k), 32'(CW'(CYC - c0)), 32'(tbl[k].dcyc));
      chk($sformatf("tbl%0d_w2", k), 32'(n2), 32'(tbl[k].nw2));
      chk($sformatf("tbl%0d_w3", k), 32'(n3), 32'(tbl[k].nw3));
    end

    repeat (3) step(0, 0, 1, 0);
    repeat (3) step(0, 1, 1, 0);
    chk("w3_after_w2_short", 32'({W3, T1}), 32'b11);
    repeat (3) step(0, 0, 0, 0);

    c0 = CYC;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    chk("stop_w1_ignored", 32'({RUN, W1, T1}), 32'b111);
    chk("stop_w1_cyc", 32'(CW'(CYC - c0)), 32'd1);
    repeat (5) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("stop_halt", 32'({T3, T2, T1, W3, W2, W1, RUN}), 32'd0);
    chk("stop_cyc", 32'(CW'(CYC - c0)), 32'd2);
    repeat (4) step(0, 0, 0, 0);
    chk("stop_stays", 32'(RUN), 32'd0);

    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("restart", 32'({T1, W1, RUN}), 32'b111);
    guard = 0;
    while (m_cyc != (1 << CW) - 2 && guard < 4000) begin
      step(0, 1, 0, 0);
      guard++;
    end
    chk("preload", 32'(CYC), 32'((1 << CW) - 2));
    repeat (3) step(0, 1, 0, 0);
    chk("cyc_max", 32'(CYC), 32'((1 << CW) - 1));
    repeat (3) step(0, 1, 0, 0);
    chk("cyc_wrap", 32'(CYC), 32'd0);

    repeat (4) step(0, 0, 0, 0);
    chk("mid_w2_t2", 32'({W2, T2}), 32'b11);
    #2 clr = 1'b0;
    #1;
    chk("async_clr", 32'({T3, T2, T1, W3, W2, W1, RUN, CYC}), 32'd0);
    model_reset();
    @(negedge CLK);
    clr = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) begin
        #2 clr = 1'b0;
        #1;
        model_reset();
        check_all("rand_clr");
        #1 clr = 1'b1;
      end
      step(($urandom_range(19) == 0) ? ~QD : QD,
           1'($urandom_range(1)), 1'($urandom_range(1)),
           $urandom_range(5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
